// File: rtl/pulse_seq_pkg.sv
// Shared types for the pulse sequencer: state encoding and reset state.
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } seq_state_t;

  localparam seq_state_t RESET_STATE = IDLE;

endpackage

// File: rtl/hold_timer.sv
// Counts consecutive HOLD cycles; pulses expired on the TIMEOUT-th one so the FSM leaves HOLD on that edge.
// Only built with PULSE_SEQ_TIMEOUT_EN; latency 0 (decoded from its own counter), no backpressure.
`ifdef PULSE_SEQ_TIMEOUT_EN
module hold_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expired
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of HOLD cycles already completed before this one
  assign expired = en && (cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (en && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/pulse_seq_fsm.sv
// Start/stop sequencer: good for len cycles, then bad until stop; optional HOLD timeout via PULSE_SEQ_TIMEOUT_EN.
// Latency 1 cycle from any accepted input to its output effect; no backpressure, outputs decoded from state only.
module pulse_seq_fsm
  import pulse_seq_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             abort,
  input  logic [CNT_W-1:0] len,
  output logic             good,
  output logic             bad,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_expired;

`ifdef PULSE_SEQ_TIMEOUT_EN
  hold_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == HOLD),
    .expired (hold_expired)
  );
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // a zero length skips RUN entirely
          state_d = (len != '0) ? RUN : HOLD;
          cnt_d   = len;
        end
      end
      RUN: begin
        if (abort || cnt_q == CNT_W'(1)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (stop || hold_expired) state_d = IDLE;
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    good      = (state_q == RUN);
    bad       = (state_q == HOLD);
    busy      = (state_q == RUN) || (state_q == HOLD);
    remaining = (state_q == RUN) ? cnt_q : '0;
  end

endmodule
